// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among writeback sources.
// Optional same-cycle forwarding of the committed write: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                         hclk,
  input  logic                         hrstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wb_stall,
  output logic                         reg_wen,
  output logic [ADDR_W-1:0]            reg_waddr,
  output logic [DATA_W-1:0]            reg_wdata,
  output logic [$clog2(NUM_REQ)-1:0]   wb_grant_id,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [ADDR_W-1:0]            fwd_raddr_1,
  input  logic [ADDR_W-1:0]            fwd_raddr_2,
  output logic                         fwd_hit_1,
  output logic                         fwd_hit_2,
  output logic [DATA_W-1:0]            fwd_data_1,
  output logic [DATA_W-1:0]            fwd_data_2,
`endif
  output logic [CNT_W-1:0]             wb_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              granted;
  logic              found;
  logic [IDX_W-1:0]  cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Scan from rr_ptr upward, wrapping at NUM_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    granted = found & ~wb_stall & hrstn;
  end

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == grant_idx) begin
        req_ready[k] = granted;
        sel_addr     = req_addr[k*ADDR_W +: ADDR_W];
        sel_data     = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      rr_ptr      <= '0;
      reg_wen     <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      wb_grant_id <= '0;
      wb_count    <= '0;
    end else begin
      reg_wen <= 1'b0;
      if (granted) begin
        rr_ptr      <= (grant_idx == IDX_W'(NUM_REQ-1)) ?
                       '0 : grant_idx + 1'b1;
        reg_waddr   <= sel_addr;
        reg_wdata   <= sel_data;
        wb_grant_id <= grant_idx;
        reg_wen     <= (sel_addr != '0);
        // x0 writes take the turn but never count.
        if (sel_addr != '0 && wb_count != '1)
          wb_count <= wb_count + 1'b1;
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_hit_1  = reg_wen & (fwd_raddr_1 == reg_waddr) &
                      (fwd_raddr_1 != '0);
  assign fwd_hit_2  = reg_wen & (fwd_raddr_2 == reg_waddr) &
                      (fwd_raddr_2 != '0);
  assign fwd_data_1 = fwd_hit_1 ? reg_wdata : '0;
  assign fwd_data_2 = fwd_hit_2 ? reg_wdata : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected
// per-cycle responses, a monitor pops and compares them.
module tb_regfile_wb_arbiter;

  localparam logic [31:0] D0 = 32'h1000_0000;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;

  logic        hclk = 1'b0;
  logic        hrstn;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wb_stall;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [1:0]  wb_grant_id;
  logic [15:0] wb_count;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  fwd_raddr_1;
  logic [4:0]  fwd_raddr_2;
  logic        fwd_hit_1;
  logic        fwd_hit_2;
  logic [31:0] fwd_data_1;
  logic [31:0] fwd_data_2;
`endif

  always #5 hclk = ~hclk;

  regfile_wb_arbiter dut (
    .hclk        (hclk),
    .hrstn       (hrstn),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wb_stall    (wb_stall),
    .reg_wen     (reg_wen),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .wb_grant_id (wb_grant_id),
`ifdef REGFILE_WB_BYPASS_EN
    .fwd_raddr_1 (fwd_raddr_1),
    .fwd_raddr_2 (fwd_raddr_2),
    .fwd_hit_1   (fwd_hit_1),
    .fwd_hit_2   (fwd_hit_2),
    .fwd_data_1  (fwd_data_1),
    .fwd_data_2  (fwd_data_2),
`endif
    .wb_count    (wb_count)
  );

  typedef struct {
    string       nm;
    logic [2:0]  rdy;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  id;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a,
                         input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  // Drive one cycle; expected ready is the pre-edge value,
  // the rest is the registered state after the edge.
  task automatic step(input string nm, input logic [2:0] v,
                      input logic [2:0] er, input logic ew,
                      input logic [4:0] ea, input logic [31:0] ed,
                      input logic [1:0] eid, input logic [15:0] ec);
    exp_t e;
    req_valid = v;
    e.nm   = nm;
    e.rdy  = er;
    e.wen  = ew;
    e.addr = ea;
    e.data = ed;
    e.id   = eid;
    e.cnt  = ec;
    q.push_back(e);
    @(posedge hclk);
    #2;
  endtask

  initial begin
    exp_t       e;
    logic [2:0] r;
    forever begin
      @(negedge hclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        r = req_ready;
        @(posedge hclk);
        #1;
        checks++;
        if (r !== e.rdy || reg_wen !== e.wen ||
            reg_waddr !== e.addr || reg_wdata !== e.data ||
            wb_grant_id !== e.id || wb_count !== e.cnt) begin
          errors++;
          $display({"FAIL %s: ready=%b wen=%b addr=%0d data=%h",
                    " id=%0d cnt=%h; expected ready=%b wen=%b",
                    " addr=%0d data=%h id=%0d cnt=%h"},
                   e.nm, r, reg_wen, reg_waddr, reg_wdata,
                   wb_grant_id, wb_count, e.rdy, e.wen, e.addr,
                   e.data, e.id, e.cnt);
        end
      end
    end
  end

  initial begin
    hrstn     = 1'b0;
    req_valid = '0;
    wb_stall  = 1'b0;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {D2, D1, D0};
`ifdef REGFILE_WB_BYPASS_EN
    fwd_raddr_1 = '0;
    fwd_raddr_2 = '0;
`endif
    @(posedge hclk);
    #2;
    step("reset", 3'b111, 3'b000, 0, 0, 0, 0, 16'd0);
    hrstn = 1'b1;

    step("rr0", 3'b111, 3'b001, 1, 1, D0, 0, 16'd1);
    step("rr1", 3'b111, 3'b010, 1, 2, D1, 1, 16'd2);
    step("rr2", 3'b111, 3'b100, 1, 3, D2, 2, 16'd3);
    step("rr3", 3'b111, 3'b001, 1, 1, D0, 0, 16'd4);
    step("rr4", 3'b111, 3'b010, 1, 2, D1, 1, 16'd5);
    step("rr5", 3'b111, 3'b100, 1, 3, D2, 2, 16'd6);

    set_req(1, 5'd5, 32'hDEAD_BEEF);
    step("single", 3'b010, 3'b010, 1, 5, 32'hDEAD_BEEF, 1, 16'd7);
    step("idle", 3'b000, 3'b000, 0, 5, 32'hDEAD_BEEF, 1, 16'd7);

    set_req(2, 5'd0, 32'h55);
    step("x0", 3'b100, 3'b100, 0, 0, 32'h55, 2, 16'd7);
    wb_stall = 1'b1;
    step("stall0", 3'b001, 3'b000, 0, 0, 32'h55, 2, 16'd7);
    step("stall1", 3'b001, 3'b000, 0, 0, 32'h55, 2, 16'd7);
    wb_stall = 1'b0;
    step("unstall", 3'b001, 3'b001, 1, 1, D0, 0, 16'd8);

    set_req(2, 5'd3, D2);
    step("rr_wrap", 3'b101, 3'b100, 1, 3, D2, 2, 16'd9);
    step("rr_back", 3'b101, 3'b001, 1, 1, D0, 0, 16'd10);

    set_req(0, 5'd9, 32'hA5A5_0000);
    set_req(1, 5'd9, 32'h5A5A_1111);
    step("same_a1", 3'b011, 3'b010, 1, 9, 32'h5A5A_1111, 1, 16'd11);
    step("same_a0", 3'b011, 3'b001, 1, 9, 32'hA5A5_0000, 0, 16'd12);

    // Bulk commits from requester 0 to bring the counter to 16'hFFFD.
    set_req(0, 5'd1, D0);
    req_valid = 3'b001;
    repeat (65521) @(posedge hclk);
    #2;
    step("sat_fffe", 3'b001, 3'b001, 1, 1, D0, 0, 16'hFFFE);
    step("sat_ffff", 3'b001, 3'b001, 1, 1, D0, 0, 16'hFFFF);
    step("sat_hold1", 3'b001, 3'b001, 1, 1, D0, 0, 16'hFFFF);
    step("sat_hold2", 3'b001, 3'b001, 1, 1, D0, 0, 16'hFFFF);

    req_valid = 3'b001;
    @(posedge hclk);
    #1;
    chk("pre_rst_wen", 32'(reg_wen), 32'd1);
    hrstn = 1'b0;
    #1;
    chk("rst_wen", 32'(reg_wen), 32'd0);
    chk("rst_cnt", 32'(wb_count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_waddr", 32'(reg_waddr), 32'd0);
    req_valid = 3'b111;
    @(posedge hclk);
    #1;
    hrstn = 1'b1;
    #1;
    step("post_rst", 3'b111, 3'b001, 1, 1, D0, 0, 16'd1);

`ifdef REGFILE_WB_BYPASS_EN
    set_req(0, 5'd7, 32'h1234_5678);
    step("byp_commit", 3'b001, 3'b001, 1, 7, 32'h1234_5678, 0, 16'd2);
    fwd_raddr_1 = 5'd7;
    fwd_raddr_2 = 5'd0;
    #1;
    chk("fwd_hit_1", 32'(fwd_hit_1), 32'd1);
    chk("fwd_data_1", fwd_data_1, 32'h1234_5678);
    chk("fwd_hit_2", 32'(fwd_hit_2), 32'd0);
    chk("fwd_data_2", fwd_data_2, 32'd0);
    fwd_raddr_1 = 5'd8;
    #1;
    chk("fwd_miss_hit", 32'(fwd_hit_1), 32'd0);
    chk("fwd_miss_data", fwd_data_1, 32'd0);
`endif

    req_valid = '0;
    repeat (3) @(posedge hclk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
